// File: rtl/fcims.sv
// rtl/fcims.sv - food-court inventory slice: per-clock sale/restock price and stock update
//
// Purpose:
//   One transaction per rising clock edge against a 4-bit stock count.
//   Computes the transaction price P = U x N and the updated count,
//   rejecting sales that exceed stock and restocks that would overflow 15.
//   Rejected transactions report P = 0 and leave the count unchanged.
//
// Ports:
//   clk                 system clock, rising edge active
//   reset               asynchronous active-low clear of all output flops
//   ctrl                mode: 0 = sale, 1 = restock
//   uprice0..uprice3    unit price U, bit 0 = LSB
//   ncel0..ncel3        quantity N, bit 0 = LSB
//   ct0..ct3            current stock count C, bit 0 = LSB
//   fprice0..fprice7    registered transaction price P, bit 0 = LSB
//   new_ct0..new_ct3    registered updated stock count, bit 0 = LSB

module fcims (
  input  logic clk,
  input  logic reset,
  input  logic ctrl,
  input  logic uprice0,
  input  logic uprice1,
  input  logic uprice2,
  input  logic uprice3,
  input  logic ncel0,
  input  logic ncel1,
  input  logic ncel2,
  input  logic ncel3,
  input  logic ct0,
  input  logic ct1,
  input  logic ct2,
  input  logic ct3,
  output logic fprice0,
  output logic fprice1,
  output logic fprice2,
  output logic fprice3,
  output logic fprice4,
  output logic fprice5,
  output logic fprice6,
  output logic fprice7,
  output logic new_ct0,
  output logic new_ct1,
  output logic new_ct2,
  output logic new_ct3
);

  logic [3:0] uprice;
  logic [3:0] ncel;
  logic [3:0] ct;

  logic [7:0] product;
  logic [4:0] restock_sum;
  logic       accept;
  logic [7:0] fprice_d;
  logic [3:0] new_ct_d;

  logic [7:0] fprice_q;
  logic [3:0] new_ct_q;

  assign uprice = {uprice3, uprice2, uprice1, uprice0};
  assign ncel   = {ncel3, ncel2, ncel1, ncel0};
  assign ct     = {ct3, ct2, ct1, ct0};

  // Zero-extend before multiplying so the full 8-bit product is kept.
  assign product     = {4'b0000, uprice} * {4'b0000, ncel};
  // Five bits so a restock past 15 is visible instead of wrapping.
  assign restock_sum = {1'b0, ct} + {1'b0, ncel};

  // N = 0 falls out as accepted in both modes with a zero product.
  always_comb begin
    accept   = 1'b0;
    fprice_d = 8'h00;
    new_ct_d = ct;
    if (ctrl) begin
      accept = (restock_sum <= 5'd15);
      if (accept) begin
        fprice_d = product;
        new_ct_d = restock_sum[3:0];
      end
    end else begin
      accept = (ct >= ncel);
      if (accept) begin
        fprice_d = product;
        new_ct_d = ct - ncel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fprice_q <= 8'h00;
      new_ct_q <= 4'h0;
    end else begin
      fprice_q <= fprice_d;
      new_ct_q <= new_ct_d;
    end
  end

  assign {fprice7, fprice6, fprice5, fprice4,
          fprice3, fprice2, fprice1, fprice0} = fprice_q;
  assign {new_ct3, new_ct2, new_ct1, new_ct0} = new_ct_q;

endmodule

// File: tb/tb_fcims.sv
// tb/tb_fcims.sv - randomized scoreboard bench for fcims

module tb_fcims;

  logic       clk;
  logic       reset;
  logic       ctrl;
  logic [3:0] u;
  logic [3:0] n;
  logic [3:0] c;
  wire  [7:0] fp;
  wire  [3:0] nc;

  typedef struct packed {
    logic [7:0] p;
    logic [3:0] ct;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  fcims dut (
    .clk(clk), .reset(reset), .ctrl(ctrl),
    .uprice0(u[0]), .uprice1(u[1]), .uprice2(u[2]), .uprice3(u[3]),
    .ncel0(n[0]), .ncel1(n[1]), .ncel2(n[2]), .ncel3(n[3]),
    .ct0(c[0]), .ct1(c[1]), .ct2(c[2]), .ct3(c[3]),
    .fprice0(fp[0]), .fprice1(fp[1]), .fprice2(fp[2]), .fprice3(fp[3]),
    .fprice4(fp[4]), .fprice5(fp[5]), .fprice6(fp[6]), .fprice7(fp[7]),
    .new_ct0(nc[0]), .new_ct1(nc[1]), .new_ct2(nc[2]), .new_ct3(nc[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer rules for a sale or restock.
  function automatic exp_t model(input int uu, input int nn, input int cc, input int mode);
    exp_t e;
    int price;
    int count;
    price = 0;
    count = cc;
    if (mode == 0) begin
      if (cc >= nn) begin
        price = uu * nn;
        count = cc - nn;
      end
    end else begin
      if (cc + nn <= 15) begin
        price = uu * nn;
        count = cc + nn;
      end
    end
    e.p  = price[7:0];
    e.ct = count[3:0];
    return e;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got fprice=%0d new_ct=%0d, expected fprice=%0d new_ct=%0d",
               name, got.p, got.ct, want.p, want.ct);
    end
  endtask

  // Push the expectation for the edge that is about to capture the inputs.
  task automatic push_edge();
    @(posedge clk);
    if (reset) exp_q.push_back(model(int'(u), int'(n), int'(c), int'(ctrl)));
    else       exp_q.push_back('0);
  endtask

  task automatic txn(input int uu, input int nn, input int cc, input int mode);
    @(negedge clk);
    u    = 4'(uu);
    n    = 4'(nn);
    c    = 4'(cc);
    ctrl = mode[0];
    push_edge();
  endtask

  // Monitor: every captured result is compared shortly after its edge.
  initial begin
    exp_t got;
    exp_t want;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got.p  = fp;
        got.ct = nc;
        check("edge_result", got, want);
      end
    end
  end

  initial begin
    exp_t got;
    exp_t zero;
    zero = '0;
    reset = 1'b0;
    ctrl  = 1'b0;
    u = 4'd8;
    n = 4'd3;
    c = 4'd3;

    #2;
    got.p = fp; got.ct = nc;
    check("reset_initial", got, zero);

    // Clock toggles while reset is held low: outputs stay 0.
    repeat (3) push_edge();

    @(negedge clk);
    reset = 1'b1;
    push_edge();                       // expects 24 / 0

    txn(8, 3, 0, 0);                   // insufficient stock
    txn(8, 3, 3, 0);                   // exact stock
    txn(15, 15, 15, 0);                // max product 225
    txn(8, 4, 6, 1);                   // restock
    txn(1, 9, 6, 1);                   // restock to exactly 15
    txn(2, 10, 6, 1);                  // restock overflow
    txn(7, 0, 9, 0);                   // N = 0 sale
    txn(7, 0, 9, 1);                   // N = 0 restock
    txn(15, 1, 15, 1);                 // restock overflow by one
    txn(15, 15, 0, 1);                 // restock 0 -> 15

    for (int i = 0; i < 400; i++)
      txn($urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 1));

    // Mid-cycle input changes must not disturb the held outputs.
    txn(8, 4, 6, 1);
    #3;
    u = 4'(~u); n = 4'(~n); c = 4'(~c); ctrl = ~ctrl;
    #1;
    got.p = fp; got.ct = nc;
    check("hold_between_edges", got, model(8, 4, 6, 1));

    // Valid sale result, then async reset between edges.
    txn(9, 2, 5, 0);
    #3;
    reset = 1'b0;
    #1;
    got.p = fp; got.ct = nc;
    check("async_reset_midcycle", got, zero);
    push_edge();                       // edge with reset low: 0
    push_edge();
    @(negedge clk);
    reset = 1'b1;
    push_edge();                       // first transaction after release

    for (int i = 0; i < 50; i++)
      txn($urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 1));

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
